// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: Moore FSM that fetches, decodes IR[31:27]
// and issues datapath strobes for the ALU-class instructions.
module control_sequencer #(
    parameter int T_MAX = 6,
    parameter int OPW   = 5
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stop,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        IncPC,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        AluEn,
    output logic [3:0]  AluOp,
    output logic        Run,
    output logic        Illegal
);

    typedef enum logic [3:0] {
        RESET_ST, T0, T1, T2, T3, T4, T5, T6, HALT
    } state_t;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(4);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5);
    localparam logic [OPW-1:0] OP_OR   = OPW'(6);
    localparam logic [OPW-1:0] OP_ROR  = OPW'(7);
    localparam logic [OPW-1:0] OP_ROL  = OPW'(8);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(9);
    localparam logic [OPW-1:0] OP_SHRA = OPW'(10);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(11);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(15);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(16);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(17);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(18);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(26);
    localparam logic [OPW-1:0] OP_HALT = OPW'(27);

    state_t         present_state, next_state;
    logic [OPW-1:0] opcode;
    logic           stop_req;
    logic           is_alu, is_muldiv, is_unary, is_nop, is_halt;
    logic [3:0]     alu_code;
    logic           halt_req;
    state_t         done_state;
    logic           unused_ir;

    assign unused_ir = ^IR[31-OPW:0];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            present_state <= RESET_ST;
            opcode        <= '0;
            stop_req      <= 1'b0;
        end else begin
            present_state <= next_state;
            if (present_state == T2)
                opcode <= IR[31:32-OPW];
            // Stop is remembered so a request made mid-instruction lands at its end
            if (present_state == HALT)
                stop_req <= 1'b0;
            else if (Stop)
                stop_req <= 1'b1;
        end
    end

    always_comb begin
        is_alu    = 1'b0;
        is_muldiv = 1'b0;
        is_unary  = 1'b0;
        is_nop    = 1'b0;
        is_halt   = 1'b0;
        alu_code  = 4'h0;
        case (opcode)
            OP_AND:  begin is_alu = 1'b1;    alu_code = 4'h0; end
            OP_OR:   begin is_alu = 1'b1;    alu_code = 4'h1; end
            OP_ADD:  begin is_alu = 1'b1;    alu_code = 4'h2; end
            OP_SUB:  begin is_alu = 1'b1;    alu_code = 4'h3; end
            OP_SHR:  begin is_alu = 1'b1;    alu_code = 4'h7; end
            OP_SHRA: begin is_alu = 1'b1;    alu_code = 4'h8; end
            OP_SHL:  begin is_alu = 1'b1;    alu_code = 4'h9; end
            OP_ROR:  begin is_alu = 1'b1;    alu_code = 4'hA; end
            OP_ROL:  begin is_alu = 1'b1;    alu_code = 4'hB; end
            OP_MUL:  begin is_muldiv = 1'b1; alu_code = 4'h4; end
            OP_DIV:  begin is_muldiv = 1'b1; alu_code = 4'h6; end
            OP_NEG:  begin is_unary = 1'b1;  alu_code = 4'hC; end
            OP_NOT:  begin is_unary = 1'b1;  alu_code = 4'hD; end
            OP_NOP:  is_nop  = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

    assign halt_req   = Stop | stop_req;
    assign done_state = halt_req ? HALT : T0;

    always_comb begin
        next_state = present_state;
        case (present_state)
            RESET_ST: next_state = T0;
            T0:       next_state = T1;
            T1:       next_state = T2;
            T2:       next_state = T3;
            T3: begin
                if (is_halt)
                    next_state = HALT;
                else if (is_alu || is_muldiv || is_unary)
                    next_state = T4;
                else
                    next_state = done_state;
            end
            T4:       next_state = is_unary ? done_state : T5;
            T5:       next_state = (is_muldiv && T_MAX > 5) ? T6 : done_state;
            T6:       next_state = done_state;
            HALT:     next_state = HALT;
            default:  next_state = RESET_ST;
        endcase
    end

    always_comb begin
        PCout    = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        MDRout   = 1'b0;
        MARin    = 1'b0;
        Zin      = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        AluEn    = 1'b0;
        AluOp    = 4'h0;
        Illegal  = 1'b0;
        Run      = (present_state != RESET_ST) && (present_state != HALT);
        case (present_state)
            T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            T2: begin MDRout = 1'b1; IRin = 1'b1; end
            T3: begin
                if (is_alu) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_muldiv) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_unary) begin
                    Grb = 1'b1; Rout = 1'b1; AluEn = 1'b1; AluOp = alu_code; Zin = 1'b1;
                end else if (!is_nop && !is_halt) begin
                    Illegal = 1'b1;
                end
            end
            T4: begin
                if (is_alu) begin
                    Grc = 1'b1; Rout = 1'b1; AluEn = 1'b1; AluOp = alu_code; Zin = 1'b1;
                end else if (is_muldiv) begin
                    Grb = 1'b1; Rout = 1'b1; AluEn = 1'b1; AluOp = alu_code; Zin = 1'b1;
                end else if (is_unary) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            T5: begin
                if (is_alu) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_muldiv) begin
                    Zlowout = 1'b1; LOin = 1'b1;
                end
            end
            T6: begin
                if (is_muldiv) begin
                    Zhighout = 1'b1; HIin = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboarded bench for control_sequencer: per-cycle expected strobe vectors
// are queued by the driver and compared by an independent negedge monitor.
module tb_control_sequencer;

    logic        Clock, Reset, Stop;
    logic [31:0] IR;
    logic PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin;
    logic HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, AluEn, Run, Illegal;
    logic [3:0] AluOp;

    control_sequencer #(.T_MAX(6), .OPW(5)) dut (
        .Clock(Clock), .Reset(Reset), .Stop(Stop), .IR(IR),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .AluEn(AluEn), .AluOp(AluOp), .Run(Run), .Illegal(Illegal)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    localparam logic [25:0] PCOUT    = 26'h1 << 25;
    localparam logic [25:0] ZLOWOUT  = 26'h1 << 24;
    localparam logic [25:0] ZHIGHOUT = 26'h1 << 23;
    localparam logic [25:0] MDROUT   = 26'h1 << 22;
    localparam logic [25:0] MARIN    = 26'h1 << 21;
    localparam logic [25:0] ZIN      = 26'h1 << 20;
    localparam logic [25:0] PCIN     = 26'h1 << 19;
    localparam logic [25:0] MDRIN    = 26'h1 << 18;
    localparam logic [25:0] IRIN     = 26'h1 << 17;
    localparam logic [25:0] YIN      = 26'h1 << 16;
    localparam logic [25:0] HIIN     = 26'h1 << 15;
    localparam logic [25:0] LOIN     = 26'h1 << 14;
    localparam logic [25:0] INCPC    = 26'h1 << 13;
    localparam logic [25:0] READ     = 26'h1 << 12;
    localparam logic [25:0] GRA      = 26'h1 << 11;
    localparam logic [25:0] GRB      = 26'h1 << 10;
    localparam logic [25:0] GRC      = 26'h1 << 9;
    localparam logic [25:0] RIN      = 26'h1 << 8;
    localparam logic [25:0] ROUT     = 26'h1 << 7;
    localparam logic [25:0] ALUEN    = 26'h1 << 6;
    localparam logic [25:0] RUN      = 26'h1 << 1;
    localparam logic [25:0] ILLEGAL  = 26'h1;

    localparam logic [25:0] T0E = PCOUT | MARIN | INCPC | ZIN | RUN;
    localparam logic [25:0] T1E = ZLOWOUT | PCIN | READ | MDRIN | RUN;
    localparam logic [25:0] T2E = MDROUT | IRIN | RUN;

    localparam logic [31:0] I_ADD  = 32'h191A0000;
    localparam logic [31:0] I_SUB  = 32'h20000000;
    localparam logic [31:0] I_MUL  = 32'h7AB00000;
    localparam logic [31:0] I_DIV  = 32'h80000000;
    localparam logic [31:0] I_NEG  = 32'h88900000;
    localparam logic [31:0] I_NOT  = 32'h90000000;
    localparam logic [31:0] I_NOP  = 32'hD0000000;
    localparam logic [31:0] I_LD   = 32'h00000000;
    localparam logic [31:0] I_HALT = 32'hD8000000;

    function automatic logic [25:0] alu(input logic [3:0] op);
        return {20'b0, op, 2'b0};
    endfunction

    logic [25:0] act;
    assign act = {PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin,
                  Yin, HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, AluEn,
                  AluOp, Run, Illegal};

    logic [25:0] exp_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          errors = 0;

    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            logic [25:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", t, act, e);
            end
        end
    end

    // exp describes the outputs of the current cycle; inputs act on the next edge
    task automatic cyc(input string tag, input logic rst, input logic stp,
                       input logic [31:0] ir, input logic [25:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        Reset = rst;
        Stop  = stp;
        IR    = ir;
        @(posedge Clock);
        #1;
    endtask

    task automatic fetch(input string tag, input logic [31:0] ir, input logic stop_t1);
        cyc({tag, "_t0"}, 1'b0, 1'b0, ir, T0E);
        cyc({tag, "_t1"}, 1'b0, stop_t1, ir, T1E);
        cyc({tag, "_t2"}, 1'b0, 1'b0, ir, T2E);
    endtask

    task automatic run_alu(input string tag, input logic [31:0] ir, input logic [3:0] op);
        fetch(tag, ir, 1'b0);
        cyc({tag, "_t3"}, 1'b0, 1'b0, ir, GRB | ROUT | YIN | RUN);
        cyc({tag, "_t4"}, 1'b0, 1'b0, ir, GRC | ROUT | ALUEN | alu(op) | ZIN | RUN);
        cyc({tag, "_t5"}, 1'b0, 1'b0, ir, ZLOWOUT | GRA | RIN | RUN);
    endtask

    task automatic run_muldiv(input string tag, input logic [31:0] ir, input logic [3:0] op);
        fetch(tag, ir, 1'b0);
        cyc({tag, "_t3"}, 1'b0, 1'b0, ir, GRA | ROUT | YIN | RUN);
        cyc({tag, "_t4"}, 1'b0, 1'b0, ir, GRB | ROUT | ALUEN | alu(op) | ZIN | RUN);
        cyc({tag, "_t5"}, 1'b0, 1'b0, ir, ZLOWOUT | LOIN | RUN);
        cyc({tag, "_t6"}, 1'b0, 1'b0, ir, ZHIGHOUT | HIIN | RUN);
    endtask

    task automatic run_unary(input string tag, input logic [31:0] ir, input logic [3:0] op);
        fetch(tag, ir, 1'b0);
        cyc({tag, "_t3"}, 1'b0, 1'b0, ir, GRB | ROUT | ALUEN | alu(op) | ZIN | RUN);
        cyc({tag, "_t4"}, 1'b0, 1'b0, ir, ZLOWOUT | GRA | RIN | RUN);
    endtask

    initial begin
        Reset = 1'b1;
        Stop  = 1'b0;
        IR    = 32'h0;
        @(posedge Clock);
        #1;
        cyc("reset_state", 1'b1, 1'b0, 32'h0, 26'h0);
        cyc("reset_rel", 1'b0, 1'b0, 32'h0, 26'h0);

        // Reset held for two cycles starting in the middle of T4
        fetch("add_pre", I_ADD, 1'b0);
        cyc("add_pre_t3", 1'b0, 1'b0, I_ADD, GRB | ROUT | YIN | RUN);
        cyc("add_pre_t4", 1'b1, 1'b0, I_ADD, GRC | ROUT | ALUEN | alu(4'h2) | ZIN | RUN);
        cyc("midrst_a", 1'b1, 1'b0, I_ADD, 26'h0);
        cyc("midrst_b", 1'b0, 1'b0, I_ADD, 26'h0);

        run_alu("add", I_ADD, 4'h2);
        run_alu("sub", I_SUB, 4'h3);
        run_muldiv("mul", I_MUL, 4'h4);
        run_muldiv("div", I_DIV, 4'h6);
        run_unary("neg", I_NEG, 4'hC);
        run_unary("not", I_NOT, 4'hD);

        fetch("nop", I_NOP, 1'b0);
        cyc("nop_t3", 1'b0, 1'b0, I_NOP, RUN);
        fetch("ld", I_LD, 1'b0);
        cyc("ld_t3", 1'b0, 1'b0, I_LD, RUN | ILLEGAL);

        fetch("halt", I_HALT, 1'b0);
        cyc("halt_t3", 1'b0, 1'b0, I_HALT, RUN);
        for (int i = 0; i < 20; i++)
            cyc("halt_hold", 1'b0, 1'b0, I_ADD, 26'h0);
        cyc("halt_rst", 1'b1, 1'b0, I_ADD, 26'h0);
        cyc("halt_rst_rel", 1'b0, 1'b0, I_ADD, 26'h0);

        // Stop pulsed in T1 takes effect after T5; IR churn after T2 is ignored
        fetch("stop", I_ADD, 1'b1);
        cyc("stop_t3", 1'b0, 1'b0, I_ADD, GRB | ROUT | YIN | RUN);
        cyc("stop_t4", 1'b0, 1'b0, I_MUL, GRC | ROUT | ALUEN | alu(4'h2) | ZIN | RUN);
        cyc("stop_t5", 1'b0, 1'b0, I_MUL, ZLOWOUT | GRA | RIN | RUN);
        cyc("stop_halt_a", 1'b0, 1'b0, I_MUL, 26'h0);
        cyc("stop_halt_b", 1'b1, 1'b0, I_MUL, 26'h0);
        cyc("stop_rst", 1'b0, 1'b0, I_MUL, 26'h0);
        run_alu("post", I_ADD, 4'h2);
        cyc("post_t0", 1'b0, 1'b0, I_ADD, T0E);

        for (int i = 0; i < 4 && exp_q.size() != 0; i++)
            @(negedge Clock);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Mini SRC control unit; the driving end of the datapath control interface.
- Issues the per-cycle strobes (PCout, MARin, Zin, Yin, register in/out selects, ALU op, ...) that the datapath consumes.
- Sequences instruction fetch (T0–T2), decodes IR[31:27] and executes the ALU-class instructions.
- Sits beside DataPath; its outputs connect 1:1 to the datapath control inputs and to the register select/encode logic.

Parameters:
- T_MAX, 6, index of the last execute step; mul/div use T6.
- OPW, 5, opcode width, taken from IR[31:27].

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high; forces RESET_ST on the next rising edge.
- Stop  in  1  request halt at the next instruction boundary.
- IR  in  32  instruction register contents from the datapath; only IR[31:27] is decoded.
- PCout, Zlowout, Zhighout, MDRout  out  1 each  bus source enables.
- MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin  out  1 each  register load enables.
- IncPC, Read  out  1 each  PC increment and memory read.
- Gra, Grb, Grc  out  1 each  select register field ra (IR[26:23]), rb (IR[22:19]) or rc (IR[18:15]).
- Rin, Rout  out  1 each  load / drive the selected general register.
- AluEn  out  1  ALU operation valid this cycle.
- AluOp  out  4  ALU operation code: AND=0, OR=1, ADD=2, SUB=3, MUL=4, DIV=6, SHR=7, SHRA=8, SHL=9, ROR=A, ROL=B, NEG=C, NOT=D.
- Run  out  1  high while sequencing, low in RESET_ST and HALT.
- Illegal  out  1  one-cycle pulse in T3 for an unsupported opcode.

Behaviour:
- Moore FSM with a registered present_state. All outputs are decoded combinationally from present_state and the latched opcode only.
- States: RESET_ST, T0, T1, T2, T3, T4, T5, T6, HALT.
- Reset: present_state goes to RESET_ST. In RESET_ST every output is 0, including AluOp=0 and Run=0.
- Reset has priority over all other transitions from any state, including mid-instruction and HALT.
- RESET_ST → T0 on the first edge with Reset=0.
- Fetch steps:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Memory is single-cycle; there is no wait state.
  - T2: MDRout, IRin.
- Opcode latch: the opcode is captured from IR[31:27] on the edge leaving T2 and is held until the next T2. IR changes outside T2 are ignored.
- ALU opcode mapping: add=3, sub=4, and=5, or=6, ror=7, rol=8, shr=9, shra=10, shl=11.
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, AluEn, AluOp=mapped code, Zin.
  - T5: Zlowout, Gra, Rin.
  - Next state T0; 6 cycles per instruction.
- mul=15, div=16:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, AluEn, AluOp=MUL/DIV, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin.
  - Next state T0; 7 cycles per instruction.
- neg=17, not=18:
  - T3: Grb, Rout, AluEn, AluOp=NEG/NOT, Zin.
  - T4: Zlowout, Gra, Rin.
  - Next state T0; 5 cycles per instruction.
- nop=26: T3 drives no strobes. Next state T0; 4 cycles.
- halt=27: T3 drives no strobes. Next state HALT.
- Any other opcode (ld, st, branch, io, ...): behaves as nop with Illegal=1 during T3.
- HALT: all outputs 0 with Run=0. HALT is left only via Reset.
- Stop:
  - Sampled only on the final execute step of an instruction. If Stop=1 there, go to HALT instead of T0.
  - Stop asserted during fetch is held off until that instruction completes.
- Strobe exclusivity: exactly one bus-source enable (PCout, Zlowout, Zhighout, MDRout, Rout) is high per cycle, or none. Gra/Grb/Grc are mutually exclusive.

Test Plan:
- Reset=1 for 2 cycles in mid-T4, then release → all outputs 0 in RESET_ST; T0 next cycle with PCout=MARin=IncPC=Zin=1, Run=1.
- IR=0x191A0000 (add r2,r3,r4) → T3 Grb+Rout+Yin; T4 Grc+Rout+AluEn, AluOp=2, Zin; T5 Zlowout+Gra+Rin; T0 again 6 cycles after the previous T0.
- IR=0x7AB00000 (mul r5,r6) → T4 AluOp=4; T5 Zlowout+LOin; T6 Zhighout+HIin; 7-cycle instruction.
- IR=0x88900000 (neg r1,r2) → T3 Grb+Rout+AluEn, AluOp=C, Zin; T4 Zlowout+Gra+Rin; returns to T0 after 5 cycles.
- IR=0x00000000 (ld) → Illegal=1 for exactly one cycle in T3, no strobes, back to T0. Then IR=0xD8000000 (halt) → HALT with Run=0; stays in HALT 20 cycles; Reset recovers.
- Stop=1 pulsed during T1 of an add → instruction completes through T5, then HALT; IR changed during T4 does not alter AluOp.
